ex_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline; consumes the registered ID/EX outputs and produces the ALU result, store data and destination register for the EX/MEM register.
- Contains the operand forwarding muxes, immediate extension, a single-cycle ALU, the HI/LO register pair and an iterative 32-cycle multiply/divide unit.
- The mul/div unit stalls the front of the pipeline through `stallMD` while it is busy.

---
 rtl/ex_stage_pkg.sv | 52 +++++
 rtl/ex_stage_if.sv | 47 ++++
 rtl/ex_stage_mul_div_unit.sv | 138 +++++++++++++
 rtl/ex_stage.sv | 117 +++++++++++
 tb/tb_ex_stage.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_pkg
// Brief    : Shared widths, opcode encodings and FSM states for the EX stage.
// Revision : 1.0
// ============================================================================
package ex_stage_pkg;

  localparam int WORD_WIDTH    = 32;
  localparam int REG_SIZE      = 5;
  localparam int ALU_OP_LENGTH = 4;
  localparam int EXT_OP_LENGTH = 2;
  localparam logic [WORD_WIDTH-1:0] ZERO_WORD = '0;

  typedef enum logic [ALU_OP_LENGTH-1:0] {
    ALU_ADD  = 4'h0, ALU_SUB   = 4'h1, ALU_AND = 4'h2, ALU_OR   = 4'h3,
    ALU_XOR  = 4'h4, ALU_NOR   = 4'h5, ALU_SLT = 4'h6, ALU_SLTU = 4'h7,
    ALU_SLL  = 4'h8, ALU_SRL   = 4'h9, ALU_SRA = 4'hA, ALU_LUI  = 4'hB,
    ALU_MULT = 4'hC, ALU_MULTU = 4'hD, ALU_DIV = 4'hE, ALU_DIVU = 4'hF
  } aluOp_e;

  typedef enum logic [EXT_OP_LENGTH-1:0] {
    EXT_ZERO  = 2'b00,
    EXT_SIGN  = 2'b01,
    EXT_UPPER = 2'b10
  } extOp_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwdSel_e;

  typedef enum logic [1:0] {
    HILO_ALU = 2'b00,
    HILO_HI  = 2'b01,
    HILO_LO  = 2'b10
  } hiloSel_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_BUSY = 2'b01,
    MD_DONE = 2'b10
  } mdState_e;

  // Opcodes C..F share the two top bits set.
  function automatic logic isMulDiv(input logic [ALU_OP_LENGTH-1:0] op);
    return op[3] & op[2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_stage_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage_if
// Brief    : ID/EX operand bundle in, EX results and mul/div status out.
// Revision : 1.0
// ============================================================================
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [WORD_WIDTH-1:0]    readData1E;
  logic [WORD_WIDTH-1:0]    readData2E;
  logic [REG_SIZE-1:0]      rtE;
  logic [REG_SIZE-1:0]      rdE;
  logic [15:0]              imm16E;
  logic [4:0]               saE;
  logic [EXT_OP_LENGTH-1:0] extOpE;
  logic [ALU_OP_LENGTH-1:0] aluOpE;
  logic                     alusrc2_muxE;
  logic [1:0]               regDst_muxE;
  logic [1:0]               hiloSelE;
  logic [1:0]               forwardAE;
  logic [1:0]               forwardBE;
  logic [WORD_WIDTH-1:0]    aluOutM;
  logic [WORD_WIDTH-1:0]    resultW;
  logic [WORD_WIDTH-1:0]    aluOutE;
  logic [WORD_WIDTH-1:0]    writeDataE;
  logic [REG_SIZE-1:0]      writeRegE;
  logic                     stallMD;
  logic [WORD_WIDTH-1:0]    hiE;
  logic [WORD_WIDTH-1:0]    loE;

  modport master (
    output readData1E, readData2E, rtE, rdE, imm16E, saE, extOpE, aluOpE,
           alusrc2_muxE, regDst_muxE, hiloSelE, forwardAE, forwardBE,
           aluOutM, resultW,
    input  aluOutE, writeDataE, writeRegE, stallMD, hiE, loE
  );

  modport slave (
    input  readData1E, readData2E, rtE, rdE, imm16E, saE, extOpE, aluOpE,
           alusrc2_muxE, regDst_muxE, hiloSelE, forwardAE, forwardBE,
           aluOutM, resultW,
    output aluOutE, writeDataE, writeRegE, stallMD, hiE, loE
  );

endinterface
`default_nettype wire

// File: rtl/ex_stage_mul_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mul_div_unit
// Brief    : Iterative shift-add multiplier / restoring divider with sign fix-up.
// Revision : 1.0
// ============================================================================
module mul_div_unit
  import ex_stage_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_isDiv,
  input  logic                  i_isSigned,
  input  logic [WORD_WIDTH-1:0] i_opA,
  input  logic [WORD_WIDTH-1:0] i_opB,
  output logic                  busy,
  output logic                  done,
  output logic [WORD_WIDTH-1:0] hi_out,
  output logic [WORD_WIDTH-1:0] lo_out
);

  localparam int c_cntWidth = $clog2(MD_CYCLES);
  localparam logic [c_cntWidth-1:0] c_lastIter = c_cntWidth'(MD_CYCLES - 1);

  mdState_e                r_state;
  mdState_e                w_stateNext;
  logic [c_cntWidth-1:0]   r_count;
  logic [WORD_WIDTH-1:0]   r_acc;
  logic [WORD_WIDTH-1:0]   r_shift;
  logic [WORD_WIDTH-1:0]   r_opB;
  logic                    r_isDiv;
  logic                    r_negQuo;
  logic                    r_negRem;
  logic                    r_divZero;

  logic [WORD_WIDTH-1:0]   w_absA;
  logic [WORD_WIDTH-1:0]   w_absB;
  logic [WORD_WIDTH:0]     w_sum;
  logic [WORD_WIDTH:0]     w_trial;
  logic [WORD_WIDTH-1:0]   w_accNext;
  logic [WORD_WIDTH-1:0]   w_shiftNext;
  logic [2*WORD_WIDTH-1:0] w_prod;

  assign w_absA = (i_isSigned && i_opA[WORD_WIDTH-1]) ? -i_opA : i_opA;
  assign w_absB = (i_isSigned && i_opB[WORD_WIDTH-1]) ? -i_opB : i_opB;

  // r_acc is the running high half (mult) or partial remainder (div);
  // r_shift holds the multiplier bits still to consume, or the quotient being built.
  assign w_sum   = {1'b0, r_acc} + {1'b0, (r_shift[0] ? r_opB : ZERO_WORD)};
  assign w_trial = {r_acc, r_shift[WORD_WIDTH-1]} - {1'b0, r_opB};

  always_comb begin
    w_accNext   = r_acc;
    w_shiftNext = r_shift;
    if (r_isDiv) begin
      if (!w_trial[WORD_WIDTH]) begin
        w_accNext   = w_trial[WORD_WIDTH-1:0];
        w_shiftNext = {r_shift[WORD_WIDTH-2:0], 1'b1};
      end else begin
        w_accNext   = {r_acc[WORD_WIDTH-2:0], r_shift[WORD_WIDTH-1]};
        w_shiftNext = {r_shift[WORD_WIDTH-2:0], 1'b0};
      end
    end else begin
      w_accNext   = w_sum[WORD_WIDTH:1];
      w_shiftNext = {w_sum[0], r_shift[WORD_WIDTH-1:1]};
    end
  end

  // Results are formed from the final step's outputs so HI/LO load on the BUSY->DONE edge.
  assign w_prod = r_negQuo ? -{w_accNext, w_shiftNext} : {w_accNext, w_shiftNext};

  always_comb begin
    hi_out = w_prod[2*WORD_WIDTH-1:WORD_WIDTH];
    lo_out = w_prod[WORD_WIDTH-1:0];
    if (r_isDiv) begin
      hi_out = r_negRem ? -w_accNext : w_accNext;
      lo_out = r_divZero ? {WORD_WIDTH{1'b1}} : (r_negQuo ? -w_shiftNext : w_shiftNext);
    end
  end

  always_comb begin
    w_stateNext = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (i_start) begin
          w_stateNext = MD_BUSY;
          busy        = 1'b1;
        end
      end
      MD_BUSY: begin
        busy = 1'b1;
        if (r_count == c_lastIter) begin
          done        = 1'b1;
          w_stateNext = MD_DONE;
        end
      end
      MD_DONE: w_stateNext = MD_IDLE;
      default: w_stateNext = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= MD_IDLE;
      r_count   <= '0;
      r_acc     <= '0;
      r_shift   <= '0;
      r_opB     <= '0;
      r_isDiv   <= 1'b0;
      r_negQuo  <= 1'b0;
      r_negRem  <= 1'b0;
      r_divZero <= 1'b0;
    end else begin
      r_state <= w_stateNext;
      if (r_state == MD_IDLE && i_start) begin
        r_count   <= '0;
        r_acc     <= '0;
        r_shift   <= w_absA;
        r_opB     <= w_absB;
        r_isDiv   <= i_isDiv;
        r_negQuo  <= i_isSigned & (i_opA[WORD_WIDTH-1] ^ i_opB[WORD_WIDTH-1]);
        r_negRem  <= i_isSigned & i_opA[WORD_WIDTH-1];
        r_divZero <= (i_opB == ZERO_WORD);
      end else if (r_state == MD_BUSY) begin
        r_acc   <= w_accNext;
        r_shift <= w_shiftNext;
        r_count <= r_count + c_cntWidth'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : ex_stage
// Brief    : MIPS execute stage: forwarding, immediate extension, ALU, HI/LO.
// Revision : 1.0
// ============================================================================
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int MD_CYCLES = 32
) (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave exBus
);

  logic [WORD_WIDTH-1:0] w_srcA;
  logic [WORD_WIDTH-1:0] w_srcB;
  logic [WORD_WIDTH-1:0] w_ext;
  logic [WORD_WIDTH-1:0] w_aluB;
  logic [WORD_WIDTH-1:0] w_alu;
  logic [WORD_WIDTH-1:0] w_mdHi;
  logic [WORD_WIDTH-1:0] w_mdLo;
  logic                  w_mdBusy;
  logic                  w_mdDone;
  logic [WORD_WIDTH-1:0] r_hi;
  logic [WORD_WIDTH-1:0] r_lo;

  // Select code 11 is unused and falls back to the register file value.
  always_comb begin
    case (exBus.forwardAE)
      FWD_W:   w_srcA = exBus.resultW;
      FWD_M:   w_srcA = exBus.aluOutM;
      default: w_srcA = exBus.readData1E;
    endcase
    case (exBus.forwardBE)
      FWD_W:   w_srcB = exBus.resultW;
      FWD_M:   w_srcB = exBus.aluOutM;
      default: w_srcB = exBus.readData2E;
    endcase
  end

  always_comb begin
    case (exBus.extOpE)
      EXT_SIGN:  w_ext = {{16{exBus.imm16E[15]}}, exBus.imm16E};
      EXT_UPPER: w_ext = {exBus.imm16E, 16'h0000};
      default:   w_ext = {16'h0000, exBus.imm16E};
    endcase
  end

  assign w_aluB = exBus.alusrc2_muxE ? w_ext : w_srcB;

  always_comb begin
    w_alu = ZERO_WORD;
    case (exBus.aluOpE)
      ALU_ADD:  w_alu = w_srcA + w_aluB;
      ALU_SUB:  w_alu = w_srcA - w_aluB;
      ALU_AND:  w_alu = w_srcA & w_aluB;
      ALU_OR:   w_alu = w_srcA | w_aluB;
      ALU_XOR:  w_alu = w_srcA ^ w_aluB;
      ALU_NOR:  w_alu = ~(w_srcA | w_aluB);
      ALU_SLT:  w_alu = {{(WORD_WIDTH-1){1'b0}}, ($signed(w_srcA) < $signed(w_aluB))};
      ALU_SLTU: w_alu = {{(WORD_WIDTH-1){1'b0}}, (w_srcA < w_aluB)};
      ALU_SLL:  w_alu = w_aluB << exBus.saE;
      ALU_SRL:  w_alu = w_aluB >> exBus.saE;
      ALU_SRA:  w_alu = $signed(w_aluB) >>> exBus.saE;
      ALU_LUI:  w_alu = w_aluB;
      default:  w_alu = ZERO_WORD;
    endcase
  end

  mul_div_unit #(
    .MD_CYCLES (MD_CYCLES)
  ) u_mulDiv (
    .clk        (clk),
    .rst        (rst),
    .i_start    (isMulDiv(exBus.aluOpE)),
    .i_isDiv    (exBus.aluOpE[1]),
    .i_isSigned (~exBus.aluOpE[0]),
    .i_opA      (w_srcA),
    .i_opB      (w_srcB),
    .busy       (w_mdBusy),
    .done       (w_mdDone),
    .hi_out     (w_mdHi),
    .lo_out     (w_mdLo)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hi <= ZERO_WORD;
      r_lo <= ZERO_WORD;
    end else if (w_mdDone) begin
      r_hi <= w_mdHi;
      r_lo <= w_mdLo;
    end
  end

  always_comb begin
    case (exBus.hiloSelE)
      HILO_HI: exBus.aluOutE = r_hi;
      HILO_LO: exBus.aluOutE = r_lo;
      default: exBus.aluOutE = w_alu;
    endcase
    case (exBus.regDst_muxE)
      2'b01:   exBus.writeRegE = exBus.rdE;
      2'b10:   exBus.writeRegE = 5'd31;
      default: exBus.writeRegE = exBus.rtE;
    endcase
  end

  assign exBus.writeDataE = w_srcB;
  assign exBus.stallMD    = w_mdBusy;
  assign exBus.hiE        = r_hi;
  assign exBus.loE        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_stage
// Brief    : Randomized self-checking bench for ex_stage against a reference model.
// Revision : 1.0
// ============================================================================
module tb_ex_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_stage_if exBus();

  ex_stage #(.MD_CYCLES(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .exBus (exBus)
  );

  int          nCompared;
  int          nMismatched;
  logic [31:0] mHi;
  logic [31:0] mLo;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] refFwd(input logic [1:0] sel, input logic [31:0] reg_, w, m);
    if (sel == 2'd1) return w;
    if (sel == 2'd2) return m;
    return reg_;
  endfunction

  function automatic logic [31:0] refExt(input logic [1:0] mode, input logic [15:0] imm);
    int unsigned u;
    int          s;
    u = imm;
    s = int'(shortint'(imm));
    if (mode == 2'd1) return s;
    if (mode == 2'd2) return u * 65536;
    return u;
  endfunction

  function automatic logic [31:0] refAlu(input int op, input logic [31:0] a, b, input int sh);
    logic [31:0] r;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ~(a | b);
      6:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      7:  return (a < b) ? 32'd1 : 32'd0;
      8:  return b << sh;
      9:  return b >> sh;
      10: begin
        r = b;
        for (int k = 0; k < sh; k++) r = {r[31], r[31:1]};
        return r;
      end
      11: return b;
      default: return 32'd0;
    endcase
  endfunction

  task automatic refMd(input int op, input logic [31:0] a, b);
    longint          sp;
    longint unsigned up;
    case (op)
      12: begin
        sp = longint'(int'(a)) * longint'(int'(b));
        {mHi, mLo} = sp;
      end
      13: begin
        up = longint'({32'd0, a}) * longint'({32'd0, b});
        {mHi, mLo} = up;
      end
      14: begin
        if (b == 32'd0) begin
          mLo = 32'hFFFFFFFF; mHi = a;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          mLo = 32'h80000000; mHi = 32'd0;
        end else begin
          mLo = int'(a) / int'(b); mHi = int'(a) % int'(b);
        end
      end
      default: begin
        if (b == 32'd0) begin
          mLo = 32'hFFFFFFFF; mHi = a;
        end else begin
          mLo = a / b; mHi = a % b;
        end
      end
    endcase
  endtask

  task automatic clearInputs();
    exBus.readData1E   = 32'd0;
    exBus.readData2E   = 32'd0;
    exBus.rtE          = 5'd0;
    exBus.rdE          = 5'd0;
    exBus.imm16E       = 16'd0;
    exBus.saE          = 5'd0;
    exBus.extOpE       = 2'd0;
    exBus.aluOpE       = 4'd0;
    exBus.alusrc2_muxE = 1'b0;
    exBus.regDst_muxE  = 2'd0;
    exBus.hiloSelE     = 2'd0;
    exBus.forwardAE    = 2'd0;
    exBus.forwardBE    = 2'd0;
    exBus.aluOutM      = 32'd0;
    exBus.resultW      = 32'd0;
  endtask

  task automatic setOp(input logic [3:0] op, input logic [31:0] a, b);
    clearInputs();
    exBus.aluOpE     = op;
    exBus.readData1E = a;
    exBus.readData2E = b;
  endtask

  // Called at a negedge; returns at the negedge after the op's DONE cycle.
  task automatic runMd(input logic [3:0] op, input logic [31:0] a, b);
    int cycles;
    cycles = 0;
    setOp(op, a, b);
    #2;
    while (exBus.stallMD && cycles < 100) begin
      cycles++;
      @(negedge clk);
      #2;
    end
    refMd(int'(op), a, b);
    checkVal("mdStallCycles", cycles, 33);
    checkVal("mdHi", exBus.hiE, mHi);
    checkVal("mdLo", exBus.loE, mLo);
    checkVal("mdAluOutZero", exBus.aluOutE, 32'd0);
    @(negedge clk);
  endtask

  task automatic readHiLo(input logic [1:0] sel, input string tag);
    clearInputs();
    exBus.hiloSelE = sel;
    #2;
    checkVal(tag, exBus.aluOutE, (sel == 2'd1) ? mHi : mLo);
    checkVal({tag, "Stall"}, 32'(exBus.stallMD), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b, bAlu, expOut, expWr;
    logic [3:0]  op;
    nCompared   = 0;
    nMismatched = 0;
    mHi         = 32'd0;
    mLo         = 32'd0;
    clearInputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    checkVal("rstStall", 32'(exBus.stallMD), 32'd0);
    checkVal("rstHi", exBus.hiE, 32'd0);
    checkVal("rstLo", exBus.loE, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    setOp(4'h0, 32'hDEADBEEF, 32'd3);
    exBus.forwardAE = 2'd2;
    exBus.aluOutM   = 32'd5;
    #2;
    checkVal("addFwdM", exBus.aluOutE, 32'd8);
    checkVal("addFwdStall", 32'(exBus.stallMD), 32'd0);
    @(negedge clk);
    setOp(4'hA, 32'd0, 32'h80000000);
    exBus.saE = 5'd4;
    #2;
    checkVal("sra", exBus.aluOutE, 32'hF8000000);
    @(negedge clk);
    setOp(4'h6, 32'hFFFFFFFF, 32'd1);
    #2;
    checkVal("sltSigned", exBus.aluOutE, 32'd1);
    @(negedge clk);
    setOp(4'h7, 32'hFFFFFFFF, 32'd1);
    #2;
    checkVal("sltu", exBus.aluOutE, 32'd0);
    @(negedge clk);

    runMd(4'hC, 32'hFFFFFFFE, 32'd3);
    checkVal("multLoConst", exBus.loE, 32'hFFFFFFFA);
    checkVal("multHiConst", exBus.hiE, 32'hFFFFFFFF);
    readHiLo(2'd2, "mfloAfterMult");
    runMd(4'hE, 32'hFFFFFFF9, 32'd2);
    checkVal("divLoConst", exBus.loE, 32'hFFFFFFFD);
    checkVal("divHiConst", exBus.hiE, 32'hFFFFFFFF);
    runMd(4'hF, 32'd7, 32'd0);
    checkVal("divuZeroLo", exBus.loE, 32'hFFFFFFFF);
    checkVal("divuZeroHi", exBus.hiE, 32'd7);
    runMd(4'hE, 32'h80000000, 32'hFFFFFFFF);

    runMd(4'hD, 32'd2, 32'd3);
    runMd(4'hD, 32'd4, 32'd5);
    checkVal("b2bLo", exBus.loE, 32'd20);
    checkVal("b2bHi", exBus.hiE, 32'd0);
    clearInputs();
    #2;
    checkVal("noRestartAfterDone", 32'(exBus.stallMD), 32'd0);
    @(negedge clk);

    setOp(4'hC, 32'h00001234, 32'h00005678);
    repeat (11) @(negedge clk);
    rst = 1'b0;
    exBus.aluOpE = 4'h0;
    @(negedge clk);
    rst = 1'b1;
    #2;
    mHi = 32'd0;
    mLo = 32'd0;
    checkVal("midRstStall", 32'(exBus.stallMD), 32'd0);
    checkVal("midRstHi", exBus.hiE, mHi);
    checkVal("midRstLo", exBus.loE, mLo);
    @(negedge clk);
    runMd(4'hC, 32'hFFFF1234, 32'h00056789);

    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(12, 15));
      a  = $urandom();
      b  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      runMd(op, a, b);
      readHiLo(2'($urandom_range(1, 2)), "mfhiloRand");
    end

    for (int i = 0; i < 150; i++) begin
      exBus.readData1E   = $urandom();
      exBus.readData2E   = $urandom();
      exBus.rtE          = 5'($urandom());
      exBus.rdE          = 5'($urandom());
      exBus.imm16E       = 16'($urandom());
      exBus.saE          = 5'($urandom());
      exBus.extOpE       = 2'($urandom_range(0, 2));
      exBus.aluOpE       = 4'($urandom_range(0, 11));
      exBus.alusrc2_muxE = 1'($urandom());
      exBus.regDst_muxE  = 2'($urandom_range(0, 2));
      exBus.hiloSelE     = 2'($urandom_range(0, 2));
      exBus.forwardAE    = 2'($urandom());
      exBus.forwardBE    = 2'($urandom());
      exBus.aluOutM      = $urandom();
      exBus.resultW      = $urandom();
      #2;
      a = refFwd(exBus.forwardAE, exBus.readData1E, exBus.resultW, exBus.aluOutM);
      b = refFwd(exBus.forwardBE, exBus.readData2E, exBus.resultW, exBus.aluOutM);
      bAlu = exBus.alusrc2_muxE ? refExt(exBus.extOpE, exBus.imm16E) : b;
      if (exBus.hiloSelE == 2'd1)      expOut = mHi;
      else if (exBus.hiloSelE == 2'd2) expOut = mLo;
      else expOut = refAlu(int'(exBus.aluOpE), a, bAlu, int'(exBus.saE));
      if (exBus.regDst_muxE == 2'd1)      expWr = 32'(exBus.rdE);
      else if (exBus.regDst_muxE == 2'd2) expWr = 32'd31;
      else expWr = 32'(exBus.rtE);
      checkVal("randAluOut", exBus.aluOutE, expOut);
      checkVal("randWriteData", exBus.writeDataE, b);
      checkVal("randWriteReg", 32'(exBus.writeRegE), expWr);
      checkVal("randStall", 32'(exBus.stallMD), 32'd0);
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
`default_nettype wire
